mem_port_arbiter: RTL

- Shares the core's single-port unified RAM between instruction fetch (IF) and the load/store unit (D).
- Owns all RAM control, address and write-data pins, and sequences one access at a time with a fixed RAM read latency.
- Data side has priority, with a starvation guard for fetch.
- Sits between core fetch/LSU logic and the RAM instance.

---
 rtl/mem_port_arbiter_if.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, D, optional loader) and RAM-side signals for mem_port_arbiter.
// The loader signals exist only when MEM_ARB_LOADER_EN is defined.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

`ifdef MEM_ARB_LOADER_EN
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [3:0]        ld_be;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
`endif

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // slave: the arbiter's view; master: requesters plus the RAM instance
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  ram_rdata,
`ifdef MEM_ARB_LOADER_EN
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_be,
    output ld_gnt, ld_rvalid, ld_rdata,
`endif
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output ram_rdata,
`ifdef MEM_ARB_LOADER_EN
    output ld_req, ld_we, ld_addr, ld_wdata, ld_be,
    input  ld_gnt, ld_rvalid, ld_rdata,
`endif
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: one access at a time, D priority with IF starvation guard.
// reset_n is synchronous and active-HIGH. MEM_ARB_LOADER_EN adds a top-priority loader port.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_LD} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT   = 3'(RAM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;

  logic ld_pending;
  logic d_wins;
  logic issue_act;
  logic done_act;

`ifdef MEM_ARB_LOADER_EN
  assign ld_pending = bus.ld_req;
`else
  assign ld_pending = 1'b0;
`endif

  assign d_wins = bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    be_d     = be_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_pending) begin
          state_d = ST_ISSUE;
          owner_d = OWN_LD;
`ifdef MEM_ARB_LOADER_EN
          we_d    = bus.ld_we;
          be_d    = bus.ld_be;
          addr_d  = bus.ld_addr;
          wdata_d = bus.ld_wdata;
`endif
        end else if (d_wins) begin
          state_d = ST_ISSUE;
          owner_d = OWN_D;
          we_d    = bus.d_we;
          be_d    = bus.d_be;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
        end else if (bus.if_req) begin
          state_d = ST_ISSUE;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          be_d    = 4'b1111;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = LAT_INIT;
        // Loader grants leave the starvation count alone.
        if (owner_q == OWN_IF) begin
          starve_d = '0;
        end else if (owner_q == OWN_D && bus.if_req && starve_q != STARVE_LIM) begin
          starve_d = starve_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (lat_q == 3'd0) state_d = ST_IDLE;
        else               lat_d   = lat_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

  // Outputs are held at zero while reset is asserted, whatever the state register holds.
  assign issue_act = !reset_n && (state_q == ST_ISSUE);
  assign done_act  = !reset_n && (state_q == ST_WAIT) && (lat_q == 3'd0);

  assign bus.ram_en    = issue_act;
  assign bus.ram_we    = issue_act && we_q;
  assign bus.ram_be    = issue_act ? be_q : 4'b0000;
  assign bus.ram_addr  = issue_act ? addr_q : '0;
  assign bus.ram_wdata = issue_act ? wdata_q : '0;

  assign bus.if_gnt    = issue_act && (owner_q == OWN_IF);
  assign bus.if_rvalid = done_act && (owner_q == OWN_IF);
  assign bus.if_rdata  = (done_act && owner_q == OWN_IF) ? bus.ram_rdata : '0;

  assign bus.d_gnt     = issue_act && (owner_q == OWN_D);
  assign bus.d_rvalid  = done_act && (owner_q == OWN_D);
  assign bus.d_rdata   = (done_act && owner_q == OWN_D && !we_q) ? bus.ram_rdata : '0;

`ifdef MEM_ARB_LOADER_EN
  assign bus.ld_gnt    = issue_act && (owner_q == OWN_LD);
  assign bus.ld_rvalid = done_act && (owner_q == OWN_LD);
  assign bus.ld_rdata  = (done_act && owner_q == OWN_LD && !we_q) ? bus.ram_rdata : '0;
`endif
endmodule
